dram_port_arbiter: RTL and testbench

//  Shares the single 16-core DRAM controller port between two requesters.

---
 rtl/dram_arb_pkg.sv | 18 +
 rtl/dram_port_arbiter_rr_arb2.sv | 32 +++
 rtl/dram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_dram_port_arbiter.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM port arbiter.
// Lane layout: lane k occupies bits [64k+63:64k].
package dram_arb_pkg;

  localparam int LANE_W    = 64;
  localparam int N_LANES   = 16;
  localparam int AW_D      = 6;
  localparam int DW_D      = LANE_W * N_LANES;
  localparam int TIMEOUT_D = 255;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/dram_port_arbiter_rr_arb2.sv
// Two-way arbiter: combinational pick plus registered last winner.
// req[0]/win[0] is requester A, req[1]/win[1] is requester B.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [1:0] req,
  input  logic       prio_a,
  input  logic       update,
  output logic [1:0] win
);

  logic last;

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req == 2'b01): win = 2'b01;
      (req == 2'b10): win = 2'b10;
      (req == 2'b11): win = (prio_a || last) ? 2'b01 : 2'b10;
      default:        win = 2'b00;
    endcase
  end

  // Reset to B so that A takes the first tie.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      last <= 1'b1;
    else if (update && (win != 2'b00))
      last <= win[1];
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Serialises A/B requesters onto one DRAM controller port.
// One transaction in flight; WAIT is bounded by a timeout.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int AW      = AW_D,
  parameter int DW      = DW_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          prio_a,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_ack,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_ack,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          dram_io_en,
  output logic          dram_we,
  output logic [AW-1:0] dram_addr,
  output logic [DW-1:0] dram_wdata,
  input  logic [DW-1:0] dram_rdata,
  input  logic          dram_done
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  state_t        state;
  state_t        nxt;
  logic [1:0]    win;
  logic          owner_b;
  logic          err_q;
  logic [CW-1:0] cnt;
  logic          any_req;
  logic          tmo;

  assign any_req = a_req | b_req;
  assign tmo     = (cnt == TMAX);

  rr_arb2 u_arb (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .req    ({b_req, a_req}),
    .prio_a (prio_a),
    .update (state == IDLE),
    .win    (win)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (any_req) nxt = ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    if (dram_done || tmo) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    dram_io_en = (state == ISSUE);
    a_gnt      = busy && !owner_b;
    b_gnt      = busy && owner_b;
    a_ack      = (state == DONE) && !owner_b;
    b_ack      = (state == DONE) && owner_b;
    err        = (state == DONE) && err_q;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      owner_b    <= 1'b0;
      dram_we    <= 1'b0;
      dram_addr  <= '0;
      dram_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      owner_b    <= win[1];
      dram_we    <= win[1] ? b_we : a_we;
      dram_addr  <= win[1] ? b_addr : a_addr;
      dram_wdata <= win[1] ? b_wdata : a_wdata;
    end
  end

  // Done has priority over timeout when both land in the same cycle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt   <= '0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      unique case (state)
        ISSUE: begin
          cnt   <= '0;
          err_q <= 1'b0;
        end
        WAIT: begin
          if (dram_done) begin
            rdata <= dram_rdata;
            err_q <= 1'b0;
          end else if (tmo) begin
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Randomised scoreboard bench for dram_port_arbiter.
// Expected issues/acks are queued by the driver and popped by a monitor.
module tb_dram_port_arbiter;

  localparam int AW  = 6;
  localparam int DW  = 1024;
  localparam int TMO = 12;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          prio_a = 1'b0;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt, a_ack;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt, b_ack;
  logic          err, busy;
  logic [DW-1:0] rdata;
  logic          dram_io_en, dram_we;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_wdata;
  logic [DW-1:0] dram_rdata = '0;
  logic          dram_done = 1'b0;

  dram_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RSTn(RSTn), .prio_a(prio_a),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_ack(b_ack),
    .err(err), .rdata(rdata), .busy(busy),
    .dram_io_en(dram_io_en), .dram_we(dram_we), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .dram_done(dram_done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    bit            who;
    bit            err;
    logic [DW-1:0] rdata;
    int            cyc;
  } ack_t;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } iss_t;

  ack_t acks[$];
  iss_t isss[$];

  int tests = 0;
  int fails = 0;

  bit            m_last = 1'b1;
  logic [DW-1:0] m_rdata = '0;

  task automatic chk(input string nm, input bit ok,
                     input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  always @(negedge CLK) begin
    if (RSTn) begin
      chk("gnt_excl", !(a_gnt && b_gnt), {a_gnt, b_gnt}, 2'b00);
      if (dram_io_en) begin
        if (isss.size() == 0) begin
          chk("unexpected_io_en", 1'b0, 1, 0);
        end else begin
          iss_t e;
          e = isss.pop_front();
          chk("io_en_cycle", cyc == e.cyc, cyc, e.cyc);
          chk("dram_we", dram_we == e.we, dram_we, e.we);
          chk("dram_addr", dram_addr == e.addr, dram_addr, e.addr);
          chk("dram_wdata", dram_wdata == e.wdata,
              dram_wdata[127:0], e.wdata[127:0]);
        end
      end
      if (a_ack || b_ack) begin
        if (acks.size() == 0) begin
          chk("unexpected_ack", 1'b0, {a_ack, b_ack}, 0);
        end else begin
          ack_t e;
          e = acks.pop_front();
          chk("ack_who", (b_ack == e.who) && (a_ack != e.who),
              {a_ack, b_ack}, e.who ? 2'b01 : 2'b10);
          chk("ack_cycle", cyc == e.cyc, cyc, e.cyc);
          chk("ack_err", err == e.err, err, e.err);
          chk("ack_gnt", e.who ? b_gnt : a_gnt, {a_gnt, b_gnt}, e.who ? 2'b01 : 2'b10);
          chk("rdata", rdata == e.rdata, rdata[127:0], e.rdata[127:0]);
        end
      end
    end
  end

  task automatic start_txn(input bit ra, input bit rb, input bit pr,
                           input bit awe, input logic [AW-1:0] aad,
                           input logic [DW-1:0] awd,
                           input bit bwe, input logic [AW-1:0] bad,
                           input logic [DW-1:0] bwd,
                           input int n, input logic [DW-1:0] drd,
                           output int t0);
    bit   w;
    iss_t i;
    ack_t a;
    if (ra && !rb)      w = 1'b0;
    else if (rb && !ra) w = 1'b1;
    else if (pr)        w = 1'b0;
    else                w = ~m_last;
    m_last = w;
    prio_a = pr;
    a_req = ra; a_we = awe; a_addr = aad; a_wdata = awd;
    b_req = rb; b_we = bwe; b_addr = bad; b_wdata = bwd;
    t0 = cyc;
    i.we    = w ? bwe : awe;
    i.addr  = w ? bad : aad;
    i.wdata = w ? bwd : awd;
    i.cyc   = t0 + 1;
    isss.push_back(i);
    if (n >= 0) m_rdata = drd;
    a.who   = w;
    a.err   = (n < 0);
    a.rdata = m_rdata;
    a.cyc   = t0 + 3 + ((n < 0) ? TMO : n);
    acks.push_back(a);
  endtask

  task automatic run_txn(input bit ra, input bit rb, input bit pr,
                         input bit awe, input logic [AW-1:0] aad,
                         input logic [DW-1:0] awd,
                         input bit bwe, input logic [AW-1:0] bad,
                         input logic [DW-1:0] bwd,
                         input int n, input logic [DW-1:0] drd,
                         input bit spur);
    int t0;
    start_txn(ra, rb, pr, awe, aad, awd, bwe, bad, bwd, n, drd, t0);
    @(negedge CLK);
    // Requester fields change after the latch cycle and must be ignored.
    a_addr = AW'($urandom); b_addr = AW'($urandom);
    a_we = ~a_we; b_we = ~b_we;
    a_wdata = rand_dw(); b_wdata = rand_dw();
    dram_done = spur;
    dram_rdata = rand_dw();
    @(negedge CLK);
    dram_done = 1'b0;
    if (n >= 0) begin
      while (cyc < t0 + 2 + n) @(negedge CLK);
      dram_done = 1'b1;
      dram_rdata = drd;
      @(negedge CLK);
      dram_done = 1'b0;
    end else begin
      while (cyc < t0 + 3 + TMO) @(negedge CLK);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(negedge CLK);
    if (spur) begin
      dram_done = 1'b1;
      dram_rdata = rand_dw();
      @(negedge CLK);
      dram_done = 1'b0;
    end
  endtask

  function automatic logic [16:0] outs_or();
    return {a_gnt, a_ack, b_gnt, b_ack, err, busy, dram_io_en, dram_we,
            dram_addr, |dram_wdata, |rdata};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] lanes, pat, z;
    logic [7:0]    kb;
    int            t0;
    z = '0;
    for (int k = 0; k < 16; k++) lanes[k*64 +: 64] = 64'(k + 1);
    for (int k = 0; k < 16; k++) begin
      kb = k[7:0];
      pat[k*64 +: 64] = {8{kb}};
    end

    repeat (3) @(negedge CLK);
    chk("reset_outputs", outs_or() == 17'd0, outs_or(), 0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("idle_after_reset", outs_or() == 17'd0, outs_or(), 0);

    run_txn(1, 0, 0, 1, 6'h05, lanes, 0, 0, z, 2, z, 0);
    for (int r = 0; r < 4; r++)
      run_txn(1, 1, 0, 1, AW'(r), rand_dw(), 1, AW'(r + 8), rand_dw(), 0, rand_dw(), 0);
    for (int r = 0; r < 4; r++)
      run_txn(1, 1, 1, 1, AW'(r), rand_dw(), 0, AW'(r + 8), rand_dw(), 1, rand_dw(), 0);
    run_txn(0, 1, 0, 0, 0, z, 0, 6'h2A, z, 1, pat, 0);
    run_txn(1, 0, 0, 1, 6'h11, rand_dw(), 0, 0, z, -1, z, 0);
    run_txn(1, 0, 0, 0, 6'h12, z, 0, 0, z, 3, rand_dw(), 0);
    run_txn(0, 1, 0, 1, 0, z, 0, 6'h13, z, TMO, rand_dw(), 1);

    start_txn(1, 0, 0, 1, 6'h21, rand_dw(), 0, 0, z, -1, z, t0);
    repeat (4) @(negedge CLK);
    #2 RSTn = 1'b0;
    #1 chk("async_reset_outputs", outs_or() == 17'd0, outs_or(), 0);
    void'(acks.pop_back());
    a_req = 1'b0;
    m_last = 1'b1;
    m_rdata = '0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    run_txn(1, 1, 0, 0, 6'h31, z, 1, 6'h32, rand_dw(), 0, rand_dw(), 0);

    for (int r = 0; r < 150; r++) begin
      bit ra, rb;
      int n;
      ra = $urandom_range(1, 0);
      rb = $urandom_range(1, 0);
      if (!ra && !rb) ra = 1'b1;
      case ($urandom_range(9, 0))
        0:       n = -1;
        1:       n = TMO;
        default: n = $urandom_range(6, 0);
      endcase
      run_txn(ra, rb, $urandom_range(1, 0),
              $urandom_range(1, 0), AW'($urandom), rand_dw(),
              $urandom_range(1, 0), AW'($urandom), rand_dw(),
              n, rand_dw(), $urandom_range(1, 0));
    end

    repeat (4) @(negedge CLK);
    chk("acks_drained", acks.size() == 0, acks.size(), 0);
    chk("issues_drained", isss.size() == 0, isss.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
